// File: rtl/temp_entry_enc_if.sv
// temp_entry_enc_if: keypad-side and display/setpoint-side signals of the
// temperature entry encoder, bundled so the encoder and its driver share one
// port list.
//
//   digit_valid  one-cycle strobe, digit carries a keypress
//   digit[3:0]   BCD digit, legal 0..9
//   enter        one-cycle strobe, commit pending entry
//   clear        one-cycle strobe, abandon pending entry and clear err
//   temp[4:0]    last committed temperature (binary)
//   temp_valid   one-cycle pulse, temp just updated
//   err          level, last action rejected
//   entry_active high while digits are pending
//   disp_dec     pending tens digit for the 7-segment driver (4'hF = blank)
//   disp_uni     pending units digit for the 7-segment driver (4'hF = blank)
//
// master: keypad/controller side (drives strobes)
// slave : encoder side (drives results)
interface temp_entry_enc_if;
  logic       digit_valid;
  logic [3:0] digit;
  logic       enter;
  logic       clear;
  logic [4:0] temp;
  logic       temp_valid;
  logic       err;
  logic       entry_active;
  logic [3:0] disp_dec;
  logic [3:0] disp_uni;

  modport master (
    output digit_valid, digit, enter, clear,
    input  temp, temp_valid, err, entry_active, disp_dec, disp_uni
  );

  modport slave (
    input  digit_valid, digit, enter, clear,
    output temp, temp_valid, err, entry_active, disp_dec, disp_uni
  );
endinterface

// File: rtl/temp_entry_enc.sv
// temp_entry_enc: decimal-to-binary entry encoder for the temperature
// setpoint. Collects up to two BCD digits (tens first, shifted in), echoes
// them for the 7-segment driver and, on enter, loads the binary value into
// temp when it does not exceed TEMP_MAX. Pending entries are abandoned after
// TIMEOUT_CYC idle cycles.
//
// Ports
//   clk    system clock, all state on rising edge
//   reset  asynchronous, active-high reset
//   bus    temp_entry_enc_if.slave (strobes in, temp/err/display out)
//
// Parameters
//   TEMP_MAX     largest accepted temperature (0..31)
//   TIMEOUT_CYC  idle cycles after the last accepted digit before abandon
//   TO_W         timeout counter width, 2**TO_W > TIMEOUT_CYC
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no digits pending, display blank
// ONE   | one digit pending (d1), shown in units position
// TWO   | two digits pending (d1 tens, d2 units)
module temp_entry_enc #(
  parameter int TEMP_MAX    = 31,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int TO_W        = 26
) (
  input  logic            clk,
  input  logic            reset,
  temp_entry_enc_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } state_t;

  localparam logic [6:0]      TMAX7   = 7'(TEMP_MAX);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [3:0]      BLANK   = 4'hF;

  state_t          state_q, state_d;
  logic [3:0]      d1_q, d1_d;
  logic [3:0]      d2_q, d2_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [4:0]      temp_q, temp_d;
  logic            tv_q, tv_d;
  logic            err_q, err_d;
  logic            act_q, act_d;
  logic [3:0]      dec_q, dec_d;
  logic [3:0]      uni_q, uni_d;

  logic            digit_ok;
  logic [6:0]      two_val;
  logic [6:0]      commit_val;
  logic            to_hit;

  assign digit_ok = (bus.digit <= 4'd9);

  // d1*10 + d2 without a multiplier; max 99 fits in 7 bits.
  assign two_val    = ({3'b000, d1_q} << 3) + ({3'b000, d1_q} << 1) + {3'b000, d2_q};
  assign commit_val = (state_q == TWO) ? two_val : {3'b000, d1_q};
  assign to_hit     = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    cnt_d   = cnt_q;
    temp_d  = temp_q;
    tv_d    = 1'b0;
    err_d   = err_q;

    // Priority: clear > enter > digit_valid; a higher strobe masks the rest.
    if (bus.clear) begin
      state_d = IDLE;
      d1_d    = 4'd0;
      d2_d    = 4'd0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (bus.enter) begin
      cnt_d = '0;
      // enter with nothing pending is ignored entirely, err kept as is
      if (state_q != IDLE) begin
        state_d = IDLE;
        d1_d    = 4'd0;
        d2_d    = 4'd0;
        if (commit_val <= TMAX7) begin
          temp_d = commit_val[4:0];
          tv_d   = 1'b1;
          err_d  = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (bus.digit_valid && digit_ok) begin
      cnt_d = '0;
      unique case (state_q)
        IDLE: begin
          d1_d    = bus.digit;
          err_d   = 1'b0;
          state_d = ONE;
        end
        ONE: begin
          d2_d    = bus.digit;
          err_d   = 1'b0;
          state_d = TWO;
        end
        default: begin
          // third digit overflows the two-digit field: drop the entry
          d1_d    = 4'd0;
          d2_d    = 4'd0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else begin
      // an illegal digit only flags err; the idle timer keeps running
      if (bus.digit_valid) begin
        err_d = 1'b1;
      end
      if (state_q == IDLE) begin
        cnt_d = '0;
      end else if (to_hit) begin
        state_d = IDLE;
        d1_d    = 4'd0;
        d2_d    = 4'd0;
        cnt_d   = '0;
        err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + TO_ONE;
      end
    end
  end

  // Display and activity flag follow the next state so they are registered
  // alongside it; the second digit shifts the first into the tens position.
  always_comb begin
    dec_d = BLANK;
    uni_d = BLANK;
    act_d = 1'b0;
    unique case (state_d)
      ONE: begin
        uni_d = d1_d;
        act_d = 1'b1;
      end
      TWO: begin
        dec_d = d1_d;
        uni_d = d2_d;
        act_d = 1'b1;
      end
      default: begin
        dec_d = BLANK;
        uni_d = BLANK;
        act_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      d1_q    <= 4'd0;
      d2_q    <= 4'd0;
      cnt_q   <= '0;
      temp_q  <= 5'd0;
      tv_q    <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= 1'b0;
      dec_q   <= BLANK;
      uni_q   <= BLANK;
    end else begin
      state_q <= state_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
      temp_q  <= temp_d;
      tv_q    <= tv_d;
      err_q   <= err_d;
      act_q   <= act_d;
      dec_q   <= dec_d;
      uni_q   <= uni_d;
    end
  end

  assign bus.temp         = temp_q;
  assign bus.temp_valid   = tv_q;
  assign bus.err          = err_q;
  assign bus.entry_active = act_q;
  assign bus.disp_dec     = dec_q;
  assign bus.disp_uni     = uni_q;

endmodule

// File: tb/tb_temp_entry_enc.sv
module tb_temp_entry_enc;
  localparam int TO   = 16;
  localparam int TMAX = 31;

  logic clk;
  logic reset;
  temp_entry_enc_if bus();

  temp_entry_enc #(.TEMP_MAX(TMAX), .TIMEOUT_CYC(TO), .TO_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // reference model: pending digits as a list, committed value, flags
  int pend[$];
  int m_temp;
  bit m_tv;
  bit m_err;
  int m_idle;

  task automatic model_reset();
    pend.delete();
    m_temp = 0;
    m_tv   = 1'b0;
    m_err  = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit dv, input int d, input bit en, input bit cl);
    int v;
    m_tv = 1'b0;
    if (cl) begin
      pend.delete();
      m_err  = 1'b0;
      m_idle = 0;
    end else if (en) begin
      if (pend.size() > 0) begin
        v = (pend.size() == 1) ? pend[0] : pend[0] * 10 + pend[1];
        if (v <= TMAX) begin
          m_temp = v;
          m_tv   = 1'b1;
          m_err  = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        pend.delete();
      end
      m_idle = 0;
    end else if (dv && d <= 9) begin
      if (pend.size() == 2) begin
        pend.delete();
        m_err = 1'b1;
      end else begin
        pend.push_back(d);
        m_err = 1'b0;
      end
      m_idle = 0;
    end else begin
      if (dv) m_err = 1'b1;
      if (pend.size() > 0) begin
        m_idle++;
        if (m_idle == TO) begin
          pend.delete();
          m_err  = 1'b1;
          m_idle = 0;
        end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic [3:0] dd;
    logic [3:0] du;
    dd = 4'hF;
    du = 4'hF;
    if (pend.size() == 1) begin
      du = 4'(pend[0]);
    end else if (pend.size() == 2) begin
      dd = 4'(pend[0]);
      du = 4'(pend[1]);
    end
    return {5'(m_temp), m_tv, m_err, (pend.size() != 0), dd, du};
  endfunction

  // {temp, temp_valid, err, entry_active, disp_dec, disp_uni}
  function automatic logic [15:0] vec(input int t, input bit tv, input bit e, input bit a,
                                      input int dd, input int du);
    return {5'(t), tv, e, a, 4'(dd), 4'(du)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {bus.temp, bus.temp_valid, bus.err, bus.entry_active, bus.disp_dec, bus.disp_uni};
  endfunction

  task automatic cycle(input bit dv, input int d, input bit en, input bit cl);
    @(negedge clk);
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.enter       = en;
    bus.clear       = cl;
    @(posedge clk);
    model_step(dv, d, en, cl);
    #1;
    bus.digit_valid = 1'b0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    model_reset();
    exp = vec(0, 0, 0, 0, 15, 15);
    checks++;
    if (dut_vec() !== exp) begin
      fails++;
      $display("FAIL reset_async: got %h expected %h", dut_vec(), exp);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== exp) begin
      fails++;
      $display("FAIL reset_release: got %h expected %h", dut_vec(), exp);
    end
  endtask

  task automatic test_entry_25();
    cycle(1, 2, 0, 0);
    checks++;
    if (dut_vec() !== vec(0, 0, 0, 1, 15, 2)) begin
      fails++;
      $display("FAIL entry25_d1: got %h expected %h", dut_vec(), vec(0, 0, 0, 1, 15, 2));
    end
    cycle(1, 5, 0, 0);
    checks++;
    if (dut_vec() !== vec(0, 0, 0, 1, 2, 5)) begin
      fails++;
      $display("FAIL entry25_d2: got %h expected %h", dut_vec(), vec(0, 0, 0, 1, 2, 5));
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(25, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL entry25_commit: got %h expected %h", dut_vec(), vec(25, 1, 0, 0, 15, 15));
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== vec(25, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL entry25_pulse_end: got %h expected %h", dut_vec(), vec(25, 0, 0, 0, 15, 15));
    end
  endtask

  task automatic test_over_max();
    cycle(1, 7, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(7, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL over_max_commit7: got %h expected %h", dut_vec(), vec(7, 1, 0, 0, 15, 15));
    end
    cycle(1, 3, 0, 0);
    cycle(1, 2, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 1, 0, 15, 15)) begin
      fails++;
      $display("FAIL over_max_32: got %h expected %h", dut_vec(), vec(7, 0, 1, 0, 15, 15));
    end
  endtask

  task automatic test_bad_digit();
    cycle(0, 0, 0, 1);
    cycle(1, 12, 0, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 1, 0, 15, 15)) begin
      fails++;
      $display("FAIL bad_digit_idle: got %h expected %h", dut_vec(), vec(7, 0, 1, 0, 15, 15));
    end
    cycle(1, 1, 0, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 0, 1, 15, 1)) begin
      fails++;
      $display("FAIL bad_digit_recover: got %h expected %h", dut_vec(), vec(7, 0, 0, 1, 15, 1));
    end
    cycle(1, 15, 0, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 1, 1, 15, 1)) begin
      fails++;
      $display("FAIL bad_digit_one: got %h expected %h", dut_vec(), vec(7, 0, 1, 1, 15, 1));
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (dut_vec() !== vec(7, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL bad_digit_clear: got %h expected %h", dut_vec(), vec(7, 0, 0, 0, 15, 15));
    end
  endtask

  task automatic test_third_digit();
    cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);
    cycle(1, 3, 0, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 1, 0, 15, 15)) begin
      fails++;
      $display("FAIL third_digit: got %h expected %h", dut_vec(), vec(7, 0, 1, 0, 15, 15));
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(7, 0, 1, 0, 15, 15)) begin
      fails++;
      $display("FAIL third_digit_enter: got %h expected %h", dut_vec(), vec(7, 0, 1, 0, 15, 15));
    end
  endtask

  task automatic test_boundaries();
    cycle(1, 3, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(31, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL bound_31: got %h expected %h", dut_vec(), vec(31, 1, 0, 0, 15, 15));
    end
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(0, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL bound_00: got %h expected %h", dut_vec(), vec(0, 1, 0, 0, 15, 15));
    end
    cycle(1, 9, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(9, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL bound_single9: got %h expected %h", dut_vec(), vec(9, 1, 0, 0, 15, 15));
    end
  endtask

  task automatic test_timeout();
    cycle(1, 4, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== vec(9, 0, 0, 1, 15, 4)) begin
      fails++;
      $display("FAIL timeout_early: got %h expected %h", dut_vec(), vec(9, 0, 0, 1, 15, 4));
    end
    cycle(0, 0, 0, 0);
    checks++;
    if (dut_vec() !== vec(9, 0, 1, 0, 15, 15)) begin
      fails++;
      $display("FAIL timeout_fire: got %h expected %h", dut_vec(), vec(9, 0, 1, 0, 15, 15));
    end
    cycle(0, 0, 1, 1);
    checks++;
    if (dut_vec() !== vec(9, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL timeout_enter_clear: got %h expected %h", dut_vec(), vec(9, 0, 0, 0, 15, 15));
    end
    // enter on the terminal cycle wins over the timeout
    cycle(1, 1, 0, 0);
    cycle(1, 2, 0, 0);
    for (int i = 0; i < TO - 1; i++) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(12, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL timeout_enter_wins: got %h expected %h", dut_vec(), vec(12, 1, 0, 0, 15, 15));
    end
  endtask

  task automatic test_priority();
    cycle(1, 8, 0, 0);
    cycle(1, 3, 1, 0);
    checks++;
    if (dut_vec() !== vec(8, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL prio_enter_over_digit: got %h expected %h", dut_vec(), vec(8, 1, 0, 0, 15, 15));
    end
    cycle(1, 2, 0, 0);
    cycle(1, 4, 1, 1);
    checks++;
    if (dut_vec() !== vec(8, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL prio_clear_over_all: got %h expected %h", dut_vec(), vec(8, 0, 0, 0, 15, 15));
    end
    cycle(1, 5, 1, 0);
    checks++;
    if (dut_vec() !== vec(8, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL prio_idle_enter_masks_digit: got %h expected %h", dut_vec(), vec(8, 0, 0, 0, 15, 15));
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 6, 0, 0);
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(6, 1, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL b2b_first: got %h expected %h", dut_vec(), vec(6, 1, 0, 0, 15, 15));
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(6, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL b2b_second: got %h expected %h", dut_vec(), vec(6, 0, 0, 0, 15, 15));
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 3, 0, 0);
    cycle(1, 0, 0, 0);
    checks++;
    if (dut_vec() !== vec(6, 0, 0, 1, 3, 0)) begin
      fails++;
      $display("FAIL reset_mid_pending: got %h expected %h", dut_vec(), vec(6, 0, 0, 1, 3, 0));
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== vec(0, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL reset_mid_async: got %h expected %h", dut_vec(), vec(0, 0, 0, 0, 15, 15));
    end
    @(negedge clk);
    reset = 1'b0;
    cycle(0, 0, 1, 0);
    checks++;
    if (dut_vec() !== vec(0, 0, 0, 0, 15, 15)) begin
      fails++;
      $display("FAIL reset_mid_enter: got %h expected %h", dut_vec(), vec(0, 0, 0, 0, 15, 15));
    end
  endtask

  task automatic test_random();
    bit dv, en, cl;
    int d;
    int prev_tv;
    prev_tv = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int k = 0; k < TO + 2; k++) begin
          cycle(0, 0, 0, 0);
          checks++;
          if (dut_vec() !== model_vec()) begin
            fails++;
            $display("FAIL random_idle n=%0d: got %h expected %h", n, dut_vec(), model_vec());
          end
        end
      end
      cl = ($urandom_range(0, 99) < 3);
      en = ($urandom_range(0, 99) < 12);
      dv = ($urandom_range(0, 99) < 45);
      d  = ($urandom_range(0, 99) < 85) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 15));
      cycle(dv, d, en, cl);
      checks++;
      if (dut_vec() !== model_vec()) begin
        fails++;
        $display("FAIL random n=%0d: got %h expected %h", n, dut_vec(), model_vec());
      end
      checks++;
      if (prev_tv == 1 && bus.temp_valid === 1'b1) begin
        fails++;
        $display("FAIL random_tv_twice n=%0d: got 1 expected 0", n);
      end
      prev_tv = (bus.temp_valid === 1'b1) ? 1 : 0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    model_reset();
    test_reset();
    test_entry_25();
    test_over_max();
    test_bad_digit();
    test_third_digit();
    test_boundaries();
    test_timeout();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
